// File: rtl/sequence_generator.sv
// sequence_generator: serial MSB-first frame transmitter with repeats, idle gaps and optional parity (SEQGEN_PARITY_EN)
module sequence_generator #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [4:0]       len,
    input  logic [3:0]       reps,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
`ifdef SEQGEN_PARITY_EN
        S_PAR,
`endif
        S_GAP,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pat_r;
    logic [4:0]       len_r;
    logic [3:0]       rep_cnt;
    logic [3:0]       gap_cnt;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    top_in;
    logic [IW-1:0]    top_r;
    logic             len_ok;
    logic             eof;

    // first-bit indices for a new request and for a repeated frame, plus request legality
    always_comb begin
        top_in = IW'(len - 5'd1);
        top_r  = IW'(len_r - 5'd1);
        len_ok = (len != 5'd0) && (len <= 5'(WIDTH));
    end

`ifdef SEQGEN_PARITY_EN
    logic parity;

    // even parity over the len_r active bits of the latched pattern
    always_comb begin
        parity = 1'b0;
        for (int i = 0; i < WIDTH; i++)
            parity = parity ^ (pat_r[i] & (i < int'(len_r)));
    end
`endif

    // end of frame: after the parity cycle when present, otherwise after bit 0
    always_comb begin
`ifdef SEQGEN_PARITY_EN
        eof = (state == S_PAR);
`else
        eof = (state == S_SHIFT) && (idx == '0);
`endif
    end

    // frame sequencer with registered outputs; reset beats abort beats everything else
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pat_r     <= '0;
            len_r     <= '0;
            rep_cnt   <= '0;
            gap_cnt   <= '0;
            idx       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && state != S_IDLE) begin
                state     <= S_IDLE;
                out       <= 1'b0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else if (eof) begin
                if (rep_cnt != '0) begin
                    rep_cnt <= rep_cnt - 4'd1;
                    if (GAP > 0) begin
                        state     <= S_GAP;
                        gap_cnt   <= 4'(GAP - 1);
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                    end else begin
                        state     <= S_SHIFT;
                        idx       <= top_r;
                        out       <= pat_r[top_r];
                        out_valid <= 1'b1;
                    end
                end else begin
                    state     <= S_DONE;
                    done      <= 1'b1;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (len_ok) begin
                                state     <= S_SHIFT;
                                pat_r     <= pattern;
                                len_r     <= len;
                                rep_cnt   <= reps;
                                idx       <= top_in;
                                out       <= pattern[top_in];
                                out_valid <= 1'b1;
                                busy      <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    S_SHIFT: begin
`ifdef SEQGEN_PARITY_EN
                        if (idx == '0) begin
                            state     <= S_PAR;
                            out       <= parity;
                            out_valid <= 1'b1;
                        end else
`endif
                        begin
                            idx <= idx - 1'b1;
                            out <= pat_r[idx - 1'b1];
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == '0) begin
                            state     <= S_SHIFT;
                            idx       <= top_r;
                            out       <= pat_r[top_r];
                            out_valid <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state     <= S_IDLE;
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter WIDTH, default 8: pattern register width; legal range 2..16.
REQ-002 Parameter GAP, default 1: idle cycles inserted between repeated frames; legal range 0..15.
REQ-003 Port clk, input, 1: single clock; all logic is rising-edge triggered.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start, input, 1: request to transmit; sampled only in IDLE.
REQ-006 Port pattern, input, WIDTH: bits to transmit; latched on an accepted start.
REQ-007 Port len, input, 5: number of pattern bits per frame; legal range 1..WIDTH.
REQ-008 Port reps, input, 4: number of extra frames; total frames = reps+1.
REQ-009 Port abort, input, 1: cancels an active transfer.
REQ-010 Port out, output, 1: serial data bit.
REQ-011 Port out_valid, output, 1: high while out carries a frame bit.
REQ-012 Port busy, output, 1: high whenever the block is not in IDLE.
REQ-013 Port done, output, 1: one-cycle pulse on normal completion.
REQ-014 Port err, output, 1: one-cycle pulse when a start is rejected.

Function
REQ-015 The block SHALL implement states IDLE, SHIFT, PAR, GAP and DONE, and all outputs SHALL be registered.
REQ-016 IDLE: if start=1 and 1<=len<=WIDTH at edge N, the block SHALL latch pattern, len and reps and enter SHIFT, with the first bit on out and out_valid=1 from edge N+1.
REQ-017 IDLE: if start=1 with len=0 or len>WIDTH, the block SHALL pulse err for one cycle, stay in IDLE and latch nothing.
REQ-018 SHIFT: bits SHALL be sent MSB-first from index len-1 down to 0, one bit per cycle, with out_valid=1.
REQ-019 After bit 0, the next state SHALL be PAR if parity is compiled in; otherwise it follows REQ-020.
REQ-020 End of frame: if frames remain, go to GAP when GAP>0, or straight back to SHIFT when GAP=0 (no bubble); otherwise go to DONE.
REQ-021 GAP SHALL last exactly GAP cycles, with out=0 and out_valid=0, then return to SHIFT starting again at bit len-1 of the latched pattern.
REQ-022 DONE SHALL last one cycle with done=1, busy=1, out_valid=0, then go to IDLE; done SHALL NOT fire on abort or reset.
REQ-023 A start that arrives while busy=1 SHALL be ignored, and SHALL raise neither err nor any change to the latched values.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with out=0 and out_valid=0; abort has priority over every other transition.
REQ-025 If start=1 is sampled in IDLE in the same cycle that DONE exits, it SHALL NOT be accepted; acceptance requires IDLE at the sampling edge.
REQ-026 The repeat counter and bit index SHALL never wrap: reps=15 yields exactly 16 frames.
REQ-027 out SHALL be 0 whenever out_valid=0.

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE, clear the latched pattern, len, reps and all counters, and drive out, out_valid, busy, done and err to 0.
REQ-029 Reset asserted mid-frame SHALL take effect on that edge, discard the remaining bits, and suppress done; reset has priority over abort and start.

Configuration
REQ-030 With macro SEQGEN_PARITY_EN defined, the block SHALL append one PAR cycle per frame, with out = even parity (XOR) of the len bits sent and out_valid=1.
REQ-031 Without SEQGEN_PARITY_EN, the PAR state and its logic SHALL be absent, and frames SHALL be exactly len bits.

Verification
REQ-032 Basic frame: reset 2 cycles; pattern=8'h07, len=3, reps=0, start at edge N -> out=1,1,1 at edges N+1..N+3 with out_valid=1; done at N+4; busy low at N+5.
REQ-033 Repeat with gap: pattern=8'h07, len=3, reps=1, GAP=1 -> out_valid sequence 1,1,1,0,1,1,1; out = 111 0 111; one done pulse.
REQ-034 Rejected start: len=0 with start -> err pulses once, busy stays 0; then len=9 with WIDTH=8 -> err again.
REQ-035 Abort and reset: pattern=8'hB5, len=8, abort after 3 bits -> IDLE next edge, no done; repeat with reset instead of abort -> all outputs 0.
REQ-036 Parity (macro defined): pattern=8'h0B, len=4 -> out=1,0,1,1,1 (parity bit 1); with the macro undefined -> out=1,0,1,1 only.
REQ-037 Back-to-back frames: GAP=0, reps=2, len=2, pattern=2'b10 -> out=1,0,1,0,1,0 contiguous, with out_valid never dropping.
